dac_spi_driver: RTL

- Downstream stage of the vector display: consumes the x/y DAC codes the frame generator produces and serialises them to a dual-channel 12-bit SPI DAC (MCP4922-style command word).
- One x/y pair per transaction: channel A = x, channel B = y, optionally latched together with an LDAC pulse.
- Valid/ready handshake lets the vector generator pace itself to the serial link instead of a fixed clock divider.

---
 rtl/dac_spi_driver.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises one x/y code pair into two 16-bit MCP4922-style SPI frames.
// Build option DAC_SPI_LDAC_EN: ldac_n idles high and pulses low once per pair to update x/y together.
module dac_spi_driver #(
    parameter int IN_WIDTH = 8,
    parameter int SCLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] x_in,
    input  logic [IN_WIDTH-1:0] y_in,
    input  logic                valid,
    output logic                ready,
    output logic                sclk,
    output logic                mosi,
    output logic                cs_n,
    output logic                ldac_n,
    output logic [2:0]          dbg_state
);
    // Handshake: a pair transfers on any clk edge where valid && ready; ready is high only in IDLE,
    // valid seen in other states is ignored, and upstream holds valid until it is accepted.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        LDAC  = 3'd4
    } state_t;

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
`ifdef DAC_SPI_LDAC_EN
    localparam logic LDAC_IDLE = 1'b1;
`else
    localparam logic LDAC_IDLE = 1'b0;
`endif

    logic [11:0] data_x;
    logic [11:0] data_y;
    logic [15:0] word_x;
    logic [15:0] word_y;

    generate
        if (IN_WIDTH >= 12) begin : g_trunc
            assign data_x = 12'(x_in >> (IN_WIDTH - 12));
            assign data_y = 12'(y_in >> (IN_WIDTH - 12));
        end else begin : g_pad
            assign data_x = {x_in, {(12 - IN_WIDTH){1'b0}}};
            assign data_y = {y_in, {(12 - IN_WIDTH){1'b0}}};
        end
    endgenerate

    // Command word: {channel, BUF=0, GA_n=1, SHDN_n=1, data}
    assign word_x = {1'b0, 3'b011, data_x};
    assign word_y = {1'b1, 3'b011, data_y};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic             ch_q, ch_d;
    logic [15:0]      word_b_q, word_b_d;
    logic [15:0]      sh_q, sh_d;
    logic             ready_q, ready_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             ldac_n_q, ldac_n_d;
    logic             div_last;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        word_b_d = word_b_q;
        sh_d     = sh_q;
        ready_d  = ready_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        ldac_n_d = ldac_n_q;
        div_last = (div_q == DIV_LAST);

        // The divider free-runs outside IDLE; every state change lands on its wrap, so each
        // state starts with div at zero and sclk can only toggle at terminal count.
        if (state_q != IDLE) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    sh_d     = word_x;
                    word_b_d = word_y;
                    ch_d     = 1'b0;
                    mosi_d   = word_x[15];
                    cs_n_d   = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    bit_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q != 5'd15) begin
                            sh_d   = {sh_q[14:0], 1'b0};
                            mosi_d = sh_q[14];
                        end
                    end else if (bit_q == 5'd15) begin
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 5'd1;
                    end
                end
            end
            GAP: begin
                if (div_last) begin
                    if (!ch_q) begin
                        ch_d    = 1'b1;
                        sh_d    = word_b_q;
                        mosi_d  = word_b_q[15];
                        cs_n_d  = 1'b0;
                        state_d = SETUP;
                    end else begin
`ifdef DAC_SPI_LDAC_EN
                        ldac_n_d = 1'b0;
                        state_d  = LDAC;
`else
                        ready_d  = 1'b1;
                        state_d  = IDLE;
`endif
                    end
                end
            end
            LDAC: begin
                if (div_last) begin
                    ldac_n_d = LDAC_IDLE;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= 5'd0;
            ch_q     <= 1'b0;
            word_b_q <= 16'h0000;
            sh_q     <= 16'h0000;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= LDAC_IDLE;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            ch_q     <= ch_d;
            word_b_q <= word_b_d;
            sh_q     <= sh_d;
            ready_q  <= ready_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            ldac_n_q <= ldac_n_d;
        end
    end

    assign ready     = ready_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign ldac_n    = ldac_n_q;
    assign dbg_state = state_q;

endmodule
